// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-port synchronous RAM.
// Optional out-of-range suppression enabled by defining RAM_ARB_BOUNDS_CHECK_EN.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wdrive,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  last_q;
  logic                  grant_any;
  logic                  grant_sel;
  logic                  oob;
  logic                  active;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  assign oob = (addr_q >= ADDR_WIDTH'(MEM_DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_any = 1'b0;
    grant_sel = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          grant_any = 1'b1;
          grant_sel = ~last_q;
        end else if (m0_req || m1_req) begin
          grant_any = 1'b1;
          grant_sel = m1_req;
        end
        if (grant_any) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (grant_any) begin
        owner_q <= grant_sel;
        we_q    <= grant_sel ? m1_we    : m0_we;
        addr_q  <= grant_sel ? m1_addr  : m0_addr;
        wdata_q <= grant_sel ? m1_wdata : m0_wdata;
        last_q  <= grant_sel;
      end
      // Read data is captured at the edge ending ACCESS; the RAM latched it mid-cycle.
      if (state_q == ACCESS && !we_q) begin
        if (owner_q) m1_rdata <= oob ? '0 : mem_rdata;
        else         m0_rdata <= oob ? '0 : mem_rdata;
      end
    end
  end

  assign m0_gnt     = rst_n & grant_any & ~grant_sel;
  assign m1_gnt     = rst_n & grant_any &  grant_sel;

  assign active     = (state_q == ACCESS) & ~oob;
  assign mem_cs     = active;
  assign mem_we     = active &  we_q;
  assign mem_wdrive = active &  we_q;
  assign mem_oe     = active & ~we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  assign m0_done    = (state_q == RESP) & ~owner_q;
  assign m1_done    = (state_q == RESP) &  owner_q;
  assign m0_err     = m0_done & oob;
  assign m1_err     = m1_done & oob;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, transaction-level reference model, directed tests.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [27:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_wdrive, mem_cs, mem_we, mem_oe;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ram_port_arbiter #(.ADDR_WIDTH(28), .DATA_WIDTH(32), .MEM_DEPTH(60)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdrive(mem_wdrive),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: write on posedge, read latched on negedge.
  logic [31:0] ram [0:63];
  logic [31:0] ram_q = '0;
  assign mem_rdata = ram_q;
  always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr[5:0]] <= mem_wdata;
  always @(negedge clk) if (mem_cs && mem_oe) ram_q <= ram[mem_addr[5:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_oob(input logic [27:0] a);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    return a >= 28'd60;
`else
    return a != a;
`endif
  endfunction

  // Reference model: a transaction occupies grant, access and response cycles.
  logic [31:0] ref_mem [0:63];
  int          free_at = 0, acc_c = -1, done_c = -1;
  bit          mlast = 1'b1, mown, mwe;
  logic [27:0] maddr;
  logic [31:0] mdat;
  logic [31:0] erd0 = '0, erd1 = '0;

  always @(negedge clk) begin
    bit       oob, acc, w, g0, g1, d0, d1;
    if (!rst_n) begin
      free_at = 0; acc_c = -1; done_c = -1; mlast = 1'b1; erd0 = '0; erd1 = '0;
      chk("reset_ctl", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
                        mem_cs, mem_we, mem_oe, mem_wdrive}, '0);
      chk("reset_data", {mem_addr, mem_wdata}, '0);
      chk("reset_rdata", {m0_rdata, m1_rdata}, '0);
    end else begin
      oob = is_oob(maddr);
      acc = (cyc == acc_c) && !oob;
      chk("mem_ctl", {mem_cs, mem_we, mem_oe, mem_wdrive}, {acc, acc & mwe, acc & ~mwe, acc & mwe});
      chk("bus_excl", mem_oe & mem_wdrive, 0);
      if (acc) chk("mem_addr", mem_addr, maddr);
      if (acc && mwe) chk("mem_wdata", mem_wdata, mdat);
      d0 = (cyc == done_c) && !mown;
      d1 = (cyc == done_c) &&  mown;
      if (cyc == done_c) begin
        if (mwe) begin
          if (!oob) ref_mem[maddr[5:0]] = mdat;
        end else if (mown) erd1 = oob ? '0 : ref_mem[maddr[5:0]];
        else               erd0 = oob ? '0 : ref_mem[maddr[5:0]];
      end
      chk("done", {m0_done, m1_done}, {d0, d1});
      chk("err", {m0_err, m1_err}, {d0 & oob, d1 & oob});
      chk("m0_rdata", m0_rdata, erd0);
      chk("m1_rdata", m1_rdata, erd1);
      g0 = 0; g1 = 0;
      if (cyc >= free_at && (m0_req || m1_req)) begin
        w = (m0_req && m1_req) ? ~mlast : m1_req;
        g0 = ~w; g1 = w;
        mown = w; mlast = w;
        mwe   = w ? m1_we    : m0_we;
        maddr = w ? m1_addr  : m0_addr;
        mdat  = w ? m1_wdata : m0_wdata;
        acc_c = cyc + 1; done_c = cyc + 2; free_at = cyc + 3;
      end
      chk("gnt", {m0_gnt, m1_gnt}, {g0, g1});
    end
  end

  task automatic txn(input bit m, input logic we, input logic [27:0] a, input logic [31:0] d,
                     output int gcyc, output logic [3:0] actl, output logic dn,
                     output logic [31:0] rd, output logic er);
    @(posedge clk); #1;
    if (m) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m ? m1_gnt : m0_gnt) begin gcyc = cyc; break; end
    end
    if (gcyc < 0) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    actl = {mem_cs, mem_we, mem_oe, mem_wdrive};
    @(negedge clk);
    dn = m ? m1_done  : m0_done;
    rd = m ? m1_rdata : m0_rdata;
    er = m ? m1_err   : m0_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          gc, ng, n;
    int          gcs [3];
    bit          seq [3];
    logic [3:0]  actl;
    logic        dn, er;
    logic [31:0] rd;

    for (int i = 0; i < 64; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[7] = 32'h12345678;  ref_mem[7] = 32'h12345678;
    ram[60] = 32'hA5A5A5A5; ref_mem[60] = 32'hA5A5A5A5;
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Simultaneous reads from reset, held: m0, m1, m0 at 3-cycle spacing.
    m0_req = 1; m0_addr = 28'd3; m1_req = 1; m1_addr = 28'd4;
    ng = 0;
    for (int k = 0; k < 30 && ng < 3; k++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin seq[ng] = m1_gnt; gcs[ng] = cyc; ng++; end
    end
    @(posedge clk); #1 m0_req = 0; m1_req = 0;
    chk("rr_count", ng, 3);
    chk("rr_first", seq[0], 0);
    chk("rr_second", seq[1], 1);
    chk("rr_third", seq[2], 0);
    chk("rr_gap1", gcs[1] - gcs[0], 3);
    chk("rr_gap2", gcs[2] - gcs[1], 3);
    repeat (3) @(posedge clk);

    // m0 write then read back.
    txn(0, 1, 28'd5, 32'hDEADBEEF, gc, actl, dn, rd, er);
    chk("wr_access", actl, 4'b1101);
    chk("wr_done", dn, 1);
    chk("wr_rdata_held", rd, 0);
    txn(0, 0, 28'd5, 32'h0, gc, actl, dn, rd, er);
    chk("rd_access", actl, 4'b1010);
    chk("rd_done", dn, 1);
    chk("rd_data", rd, 32'hDEADBEEF);

    // m1 read of preloaded word leaves m0 untouched.
    txn(1, 0, 28'd7, 32'h0, gc, actl, dn, rd, er);
    chk("m1_rd_data", rd, 32'h12345678);
    chk("m0_rdata_kept", m0_rdata, 32'hDEADBEEF);

    // m0 pulses req only during m1's ACCESS: withdrawn, no side effect.
    @(posedge clk); #1 m1_req = 1; m1_we = 0; m1_addr = 28'd7;
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin @(negedge clk); if (m1_gnt) n = 1; end
    chk("wd_m1_gnt", n, 1);
    @(posedge clk); #1 m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 28'd9; m0_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("wd_no_gnt_acc", m0_gnt, 0);
    chk("wd_addr", mem_addr, 28'd7);
    @(posedge clk); #1 m0_req = 0;
    @(negedge clk);
    chk("wd_m1_done", m1_done, 1);
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(m0_gnt) + int'(mem_cs); end
    chk("wd_quiet", n, 0);
    chk("wd_ram_untouched", ram[9], 0);

    // Address at MEM_DEPTH.
    txn(1, 0, 28'd60, 32'h0, gc, actl, dn, rd, er);
    chk("oob_done", dn, 1);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    chk("oob_access", actl, 4'b0000);
    chk("oob_err", er, 1);
    chk("oob_rdata", rd, 0);
`else
    chk("oob_access", actl, 4'b1010);
    chk("oob_err", er, 0);
    chk("oob_rdata", rd, 32'hA5A5A5A5);
`endif

    // Reset during ACCESS of an m0 read.
    @(posedge clk); #1 m0_req = 1; m0_we = 0; m0_addr = 28'd7;
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin @(negedge clk); if (m0_gnt) n = 1; end
    chk("rst_m0_gnt", n, 1);
    @(posedge clk); #1 rst_n = 0; m0_req = 0;
    #1;
    chk("rst_immediate", {mem_cs, mem_oe, m0_done, m0_rdata}, '0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(m0_done); end
    chk("rst_no_done", n, 0);
    @(posedge clk); #1 m0_req = 1; m1_req = 1; m0_addr = 28'd1; m1_addr = 28'd2;
    @(negedge clk);
    chk("rst_tie", {m0_gnt, m1_gnt}, 2'b10);
    @(posedge clk); #1 m0_req = 0; m1_req = 0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
